// File: rtl/shifter_pkg.sv
// Shared types and helpers for the iterative shifter (shift_right_iter).
// Holds the FSM state encoding, the shift-kind/direction encodings and a
// helper that returns how many SHIFT cycles a given shift amount needs.
package shifter_pkg;

    // Controller states: wait for a request, shift, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Shift kind as seen on arith_i.
    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

    // Shift direction as carried through the datapath.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Number of SHIFT-state cycles needed to move 'shamt' bits at 'step' bits per cycle.
    // 'step' is always an elaboration-time constant at the call sites, so the
    // division folds away.
    function automatic int unsigned ceil_steps(input int unsigned shamt,
                                               input int unsigned step);
        int unsigned steps;
        if (step == 32'd0) begin
            steps = 32'd0;
        end else begin
            steps = (shamt + step - 32'd1) / step;
        end
        return steps;
    endfunction

endpackage : shifter_pkg

// File: rtl/shift_step.sv
// Combinational single-step shifter used by shift_right_iter.
// Shifts 'value_i' by 'amount_i' (never more than STEP) in one direction:
//   dir_i = DIR_RIGHT : right shift, vacated MSBs take 'fill_i'
//   dir_i = DIR_LEFT  : left shift, vacated LSBs are zero
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 1
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             fill_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] value_o
);

    logic [2*WIDTH-1:0] w_ext;
    logic [2*WIDTH-1:0] w_right;
    logic [WIDTH-1:0]   w_left;

    // Form both shift results and pick the one for the requested direction.
    always_comb begin
        w_ext   = {{WIDTH{fill_i}}, value_i};
        w_right = w_ext >> amount_i;
        w_left  = value_i << amount_i;
        if (dir_i == DIR_LEFT) begin
            value_o = w_left;
        end else begin
            value_o = w_right[WIDTH-1:0];
        end
    end

endmodule : shift_step

// File: rtl/shift_right_iter.sv
// shift_right_iter: multi-cycle right shifter (SRL/SRA) for the ALU shift path.
// A request is accepted in IDLE; the operand is then shifted STEP bits per
// cycle until the requested amount is consumed, and the result is presented
// with a one-cycle done_o pulse. busy_o covers every non-IDLE cycle so the
// control unit can stall the pipeline.
//
// Build option: define SHIFT_RIGHT_ITER_LEFT_EN to add the dir_i port
// (1 = logical left shift, arith_i ignored). Without it the block only shifts right.
module shift_right_iter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
`ifdef SHIFT_RIGHT_ITER_LEFT_EN
    input  logic               dir_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    // Width of a per-cycle shift amount: must hold values 0..STEP.
    localparam int AMT_W = $clog2(STEP + 1);

    // FSM and datapath registers.
    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_remaining;
    logic               r_fill;
    logic               r_dir;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    // Combinational helpers.
    logic               w_cap_dir;
    logic               w_cap_fill;
    logic               w_cap_no_shift;
    logic               w_last;
    logic [AMT_W-1:0]   w_amt;
    logic [SHAMT_W-1:0] w_amt_dec;
    logic [WIDTH-1:0]   w_step_out;

    // Direction captured with the request; fixed to right when the left option is absent.
`ifdef SHIFT_RIGHT_ITER_LEFT_EN
    assign w_cap_dir = dir_i;
`else
    assign w_cap_dir = DIR_RIGHT;
`endif

    // Request-side decode: fill bit (sign only for arithmetic right shifts)
    // and whether the request needs any shift cycles at all.
    always_comb begin
        w_cap_fill     = 1'b0;
        w_cap_no_shift = 1'b0;
        if ((arith_i == SHIFT_ARITH) && (w_cap_dir == DIR_RIGHT)) begin
            w_cap_fill = data_i[WIDTH-1];
        end else begin
            w_cap_fill = 1'b0;
        end
        if (ceil_steps(32'(shamt_i), 32'(STEP)) == 32'd0) begin
            w_cap_no_shift = 1'b1;
        end else begin
            w_cap_no_shift = 1'b0;
        end
    end

    // Per-cycle amount: a full STEP, or whatever is left on the final cycle.
    always_comb begin
        w_last    = 1'b0;
        w_amt     = AMT_W'(STEP);
        w_amt_dec = '0;
        if (32'(r_remaining) <= 32'(STEP)) begin
            w_last = 1'b1;
            w_amt  = AMT_W'(r_remaining);
        end else begin
            w_last = 1'b0;
            w_amt  = AMT_W'(STEP);
        end
        w_amt_dec = SHAMT_W'(w_amt);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_shift_step (
        .value_i  (r_work),
        .amount_i (w_amt),
        .fill_i   (r_fill),
        .dir_i    (r_dir),
        .value_o  (w_step_out)
    );

    // Controller FSM with registered busy/done/result; reset aborts any request in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_remaining <= '0;
            r_fill      <= 1'b0;
            r_dir       <= DIR_RIGHT;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_work      <= data_i;
                        r_remaining <= shamt_i;
                        r_fill      <= w_cap_fill;
                        r_dir       <= w_cap_dir;
                        r_busy      <= 1'b1;
                        if (w_cap_no_shift) begin
                            // Nothing to shift: the operand is already the result.
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= data_i;
                        end else begin
                            r_state <= SHIFT;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_work      <= w_step_out;
                    r_remaining <= r_remaining - w_amt_dec;
                    if (w_last) begin
                        // Final partial/full step lands straight in the result register.
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= w_step_out;
                    end else begin
                        r_state <= SHIFT;
                        r_done  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_remaining <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule : shift_right_iter

// File: tb/tb_shift_right_iter.sv
// Directed self-checking bench for shift_right_iter (WIDTH=32, STEP=1).
// Latency is counted in falling edges after the accepting rising edge: the
// n-th falling edge lies in cycle n after acceptance.
`timescale 1ns/1ps
module tb_shift_right_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        arith;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_pass;

    shift_right_iter #(
        .WIDTH   (32),
        .SHAMT_W (5),
        .STEP    (1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .data_i   (data),
        .shamt_i  (shamt),
        .arith_i  (arith),
`ifdef SHIFT_RIGHT_ITER_LEFT_EN
        .dir_i    (dir),
`endif
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report any mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Issue one request and follow it to done_o.
    // prev_res : result_o expected to be held while the request is in flight
    // pulse_at : cycle at which a second (to-be-ignored) start is pulsed, 0 = none
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sa,
                          input logic ar, input logic dr, input logic [31:0] exp_res,
                          input int exp_lat, input logic [31:0] prev_res,
                          input int pulse_at, input logic [31:0] pulse_data);
        int n;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        check_val({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        data  = d;
        shamt = sa;
        arith = ar;
        dir   = dr;
        @(posedge clk);
        #1;
        start = 1'b0;
        n        = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (n == pulse_at) begin
                start = 1'b1;
                data  = 32'h0000_0001;
                shamt = 5'd1;
                arith = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (n == 1 && exp_lat > 1) begin
                check_val({tag, "_held"}, result, prev_res);
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_val({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check_val({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check_val({tag, "_result"}, result, exp_res);
    endtask

    initial begin
        int done_hits;
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        start = 1'b0;
        data  = 32'd0;
        shamt = 5'd0;
        arith = 1'b0;
        dir   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", result, 32'd0);
        rst = 1'b0;

        // 1: logical right shift by 4.
        run_op("t1_srl4", 32'h8000_00F0, 5'd4, 1'b0, 1'b0, 32'h0800_000F, 5, 32'h0000_0000, 0, 32'd0);
        // 2: same operand, arithmetic (issued back to back, in the cycle after done).
        run_op("t2_sra4", 32'h8000_00F0, 5'd4, 1'b1, 1'b0, 32'hF800_000F, 5, 32'h0800_000F, 0, 32'd0);
        // done is a single-cycle pulse.
        @(negedge clk);
        check_val("t2_done_pulse", {31'd0, done}, 32'd0);
        check_val("t2_result_hold", result, 32'hF800_000F);
        // 3: zero shift.
        run_op("t3_sh0", 32'h1234_5678, 5'd0, 1'b0, 1'b0, 32'h1234_5678, 1, 32'hF800_000F, 0, 32'd0);
        // 4: shamt=31 arithmetic with a second start at cycle 10 that must be ignored.
        run_op("t4_sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, 32, 32'h1234_5678, 10, 32'h0000_0001);
        @(negedge clk);
        check_val("t4_no_queue_busy", {31'd0, busy}, 32'd0);
        // Extra patterns: logical shift by 31, arithmetic by 16 on a negative operand.
        run_op("t4b_srl31", 32'h8000_0001, 5'd31, 1'b0, 1'b0, 32'h0000_0001, 32, 32'hFFFF_FFFF, 0, 32'd0);
        run_op("t4c_sra16", 32'hF0F0_0000, 5'd16, 1'b1, 1'b0, 32'hFFFF_F0F0, 17, 32'h0000_0001, 0, 32'd0);
        run_op("t4d_sra_pos", 32'h4000_0000, 5'd3, 1'b1, 1'b0, 32'h0800_0000, 4, 32'hFFFF_F0F0, 0, 32'd0);

        // 5: reset in cycle 3 of a shamt=8 request.
        @(negedge clk);
        start = 1'b1;
        data  = 32'hFF00_0000;
        shamt = 5'd8;
        arith = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("t5_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
        check_val("t5_rst_done", {31'd0, done}, 32'd0);
        check_val("t5_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        check_val("t5_no_done", 32'(done_hits), 32'd0);
        run_op("t5_after_rst", 32'h0000_0010, 5'd1, 1'b0, 1'b0, 32'h0000_0008, 2, 32'h0000_0000, 0, 32'd0);

`ifdef SHIFT_RIGHT_ITER_LEFT_EN
        // 6: left shifts; arith_i has no effect on them.
        run_op("t6_sll2", 32'h0000_0003, 5'd2, 1'b0, 1'b1, 32'h0000_000C, 3, 32'h0000_0008, 0, 32'd0);
        run_op("t6_sll1_ar", 32'h8000_0001, 5'd1, 1'b1, 1'b1, 32'h0000_0002, 2, 32'h0000_000C, 0, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_right_iter
